// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a scanned two-digit common-anode display, decodes
// the settled segment patterns back to BCD and publishes a debounced value.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned STABLE_FRAMES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  input  logic [1:0] sel_in,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic [6:0] value,
  output logic       value_valid,
  output logic       value_update,
  output logic       err_pulse,
  output logic [7:0] err_count
);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES);
  localparam int unsigned MW = $clog2(STABLE_FRAMES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_FULL  = MW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {WAIT_BOTH, GOT_ONES, GOT_TENS} state_t;

  logic [9:0]    r_sync1, r_sync2, r_last;
  logic [SW-1:0] r_settle;
  logic          r_taken;
  logic [TW-1:0] r_to;
  state_t        r_state, w_next;
  logic [3:0]    r_ones, r_tens, r_cand_t, r_cand_o;
  logic [MW-1:0] r_mcnt, w_mcnt_nx;

  logic       w_change, w_sample;
  logic [1:0] w_sel;
  logic [6:0] w_pat;
  logic [3:0] w_dig;
  logic       w_dig_ok, w_blank;
  logic       w_is_ones, w_is_tens, w_err, w_discard;
  logic       w_ones_acc, w_tens_acc, w_accept, w_timeout;
  logic       w_frame, w_same, w_commit;
  logic [3:0] w_fr_tens, w_fr_ones;
  logic [6:0] w_fr_value;

  assign w_change = (r_sync2 != r_last);
  assign w_sample = !w_change && !r_taken && (r_settle == SETTLE_LAST);
  assign w_sel    = r_sync2[9:8];
  assign w_pat    = r_sync2[6:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_last   <= '1;
      r_settle <= '0;
      r_taken  <= 1'b0;
    end else begin
      r_sync1 <= {sel_in, seg_in};
      r_sync2 <= r_sync1;
      r_last  <= r_sync2;
      if (w_change) begin
        r_settle <= '0;
        r_taken  <= 1'b0;
      end else begin
        if (r_settle != SETTLE_LAST) r_settle <= r_settle + 1'b1;
        if (w_sample) r_taken <= 1'b1;
      end
    end
  end

  always_comb begin
    w_dig    = '0;
    w_dig_ok = 1'b1;
    w_blank  = 1'b0;
    case (w_pat)
      7'h40: w_dig = 4'd0;
      7'h79: w_dig = 4'd1;
      7'h24: w_dig = 4'd2;
      7'h30: w_dig = 4'd3;
      7'h19: w_dig = 4'd4;
      7'h12: w_dig = 4'd5;
      7'h02: w_dig = 4'd6;
      7'h78: w_dig = 4'd7;
      7'h00: w_dig = 4'd8;
      7'h10: w_dig = 4'd9;
      7'h7F: begin w_dig_ok = 1'b0; w_blank = 1'b1; end
      default: w_dig_ok = 1'b0;
    endcase
  end

  // Blank tens reads as 0 (w_dig stays 0); blank ones drops the frame silently.
  assign w_is_ones  = w_sample && (w_sel == 2'b10);
  assign w_is_tens  = w_sample && (w_sel == 2'b01);
  assign w_err      = (w_sample && (w_sel == 2'b00)) ||
                      ((w_is_ones || w_is_tens) && !w_dig_ok && !w_blank);
  assign w_discard  = w_is_ones && w_blank;
  assign w_ones_acc = w_is_ones && w_dig_ok;
  assign w_tens_acc = w_is_tens && (w_dig_ok || w_blank);
  assign w_accept   = w_ones_acc || w_tens_acc;
  assign w_timeout  = !w_accept && (r_to == TO_LAST);

  always_comb begin
    w_next    = r_state;
    w_frame   = 1'b0;
    w_fr_tens = r_tens;
    w_fr_ones = r_ones;
    if (w_err || w_timeout || w_discard) begin
      w_next = WAIT_BOTH;
    end else begin
      case (r_state)
        WAIT_BOTH: begin
          if (w_ones_acc)      w_next = GOT_ONES;
          else if (w_tens_acc) w_next = GOT_TENS;
        end
        GOT_ONES: begin
          if (w_tens_acc) begin
            w_frame   = 1'b1;
            w_fr_tens = w_dig;
            w_next    = WAIT_BOTH;
          end
        end
        GOT_TENS: begin
          if (w_ones_acc) begin
            w_frame   = 1'b1;
            w_fr_ones = w_dig;
            w_next    = WAIT_BOTH;
          end
        end
        default: w_next = WAIT_BOTH;
      endcase
    end
  end

  // match_cnt of 0 means no candidate, so the first frame always seeds it.
  assign w_same     = (r_mcnt != '0) && ({w_fr_tens, w_fr_ones} == {r_cand_t, r_cand_o});
  assign w_mcnt_nx  = !w_same ? MW'(1) : ((r_mcnt == MATCH_FULL) ? r_mcnt : r_mcnt + 1'b1);
  assign w_commit   = w_frame && (w_mcnt_nx == MATCH_FULL);
  assign w_fr_value = 7'(w_fr_tens) * 7'd10 + 7'(w_fr_ones);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= WAIT_BOTH;
      r_ones       <= '0;
      r_tens       <= '0;
      r_cand_t     <= '0;
      r_cand_o     <= '0;
      r_mcnt       <= '0;
      r_to         <= '0;
      digit_tens   <= '0;
      digit_ones   <= '0;
      value        <= '0;
      value_valid  <= 1'b0;
      value_update <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
    end else begin
      r_state      <= w_next;
      value_update <= 1'b0;
      err_pulse    <= w_err;
      if (w_err && (err_count != '1)) err_count <= err_count + 1'b1;
      if (w_ones_acc) r_ones <= w_dig;
      if (w_tens_acc) r_tens <= w_dig;

      if (w_err || w_timeout) begin
        r_mcnt <= '0;
      end else if (w_frame) begin
        r_mcnt <= w_mcnt_nx;
        if (!w_same) begin
          r_cand_t <= w_fr_tens;
          r_cand_o <= w_fr_ones;
        end
      end

      if (w_commit) begin
        digit_tens   <= w_fr_tens;
        digit_ones   <= w_fr_ones;
        value        <= w_fr_value;
        value_valid  <= 1'b1;
        value_update <= !value_valid || ({w_fr_tens, w_fr_ones} != {digit_tens, digit_ones});
      end

      if (w_accept)            r_to <= '0;
      else if (r_to != TO_MAX) r_to <= r_to + 1'b1;
      if (w_timeout) value_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: dwell-level stimulus checked against
// a frame/debounce reference model built from the decoding rules.
module tb_seg_scan_decoder;
  localparam int S   = 4;
  localparam int STB = 2;
  localparam int T   = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] seg_in = 8'hFF;
  logic [1:0] sel_in = 2'b11;
  logic [3:0] digit_tens, digit_ones;
  logic [6:0] value;
  logic       value_valid, value_update, err_pulse;
  logic [7:0] err_count;

  seg_scan_decoder #(.SETTLE_CYCLES(S), .STABLE_FRAMES(STB), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .sel_in(sel_in),
    .digit_tens(digit_tens), .digit_ones(digit_ones), .value(value),
    .value_valid(value_valid), .value_update(value_update),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int obs_upd = 0;
  int obs_err = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (value_update === 1'b1) obs_upd++;
    if (err_pulse === 1'b1)    obs_err++;
  end

  int n_vec = 0;
  int n_mis = 0;

  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state: pending digits, candidate, committed value.
  bit m_valid, p_o, p_t, m_to;
  int m_tens, m_ones, pv_o, pv_t, c_t, c_o, mcnt, m_errs, m_last;
  int exp_upd = 0;
  int exp_err = 0;
  logic [9:0] prev = 10'h3FF;

  wire [23:0] act = {value_valid, value, digit_tens, digit_ones, err_count};

  function automatic logic [23:0] mexp();
    return {m_valid, 7'(m_tens * 10 + m_ones), 4'(m_tens), 4'(m_ones), 8'(m_errs)};
  endfunction

  function automatic int dec(input logic [6:0] p);
    if (p == 7'h7F) return 10;
    for (int i = 0; i < 10; i++) if (pat[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [7:0] enc(input int d);
    logic [7:0] s;
    s = (d == 10) ? 8'hFF : {1'b1, pat[d]};
    s[7] = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic m_tick(input int e);
    if (!m_to && e >= m_last + T) begin
      m_to = 1; m_valid = 0; p_o = 0; p_t = 0; mcnt = 0;
    end
  endtask

  task automatic m_frame(input int t, input int o);
    if (mcnt > 0 && t == c_t && o == c_o) begin
      if (mcnt < STB) mcnt++;
    end else begin
      c_t = t; c_o = o; mcnt = 1;
    end
    if (mcnt == STB) begin
      if (!m_valid || t != m_tens || o != m_ones) exp_upd++;
      m_tens = t; m_ones = o; m_valid = 1;
    end
  endtask

  task automatic m_sample(input logic [1:0] sel, input logic [7:0] seg, input int ts);
    int d;
    bit acc;
    d = dec(seg[6:0]);
    acc = (sel == 2'b10 && d >= 0 && d <= 9) || (sel == 2'b01 && d >= 0);
    if (acc) m_tick(ts - 1); else m_tick(ts);
    if (sel == 2'b11) return;
    if (sel == 2'b00 || d < 0) begin
      if (m_errs < 255) m_errs++;
      exp_err++; p_o = 0; p_t = 0; mcnt = 0;
    end else if (sel == 2'b10 && d == 10) begin
      p_o = 0; p_t = 0;
    end else begin
      if (sel == 2'b10) begin p_o = 1; pv_o = d; end
      else begin p_t = 1; pv_t = (d == 10) ? 0 : d; end
      m_last = ts; m_to = 0;
      if (p_o && p_t) begin
        p_o = 0; p_t = 0;
        m_frame(pv_t, pv_o);
      end
    end
  endtask

  task automatic dwell(input logic [1:0] sel, input logic [7:0] seg, input int len);
    int t0;
    if ({sel, seg} == prev) seg[7] = ~seg[7];
    sel_in = sel;
    seg_in = seg;
    prev = {sel, seg};
    t0 = cyc + 1;
    if (len >= S + 1 && sel != 2'b11) m_sample(sel, seg, t0 + S + 2);
    repeat (len) @(negedge clk);
    #1;
    m_tick(cyc);
  endtask

  task automatic frame(input int t, input int o, input int len);
    dwell(2'b10, enc(o), len);
    dwell(2'b01, enc(t), len);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sel_in = 2'b11; seg_in = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    m_valid = 0; p_o = 0; p_t = 0; m_to = 0;
    m_tens = 0; m_ones = 0; c_t = 0; c_o = 0; mcnt = 0; m_errs = 0;
    m_last = cyc; prev = 10'h3FF;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({act, value_update, err_pulse} !== 26'h0) begin
      n_mis++; $display("FAIL reset_outputs got=%h want=0", {act, value_update, err_pulse});
    end
  endtask

  task automatic test_clean_scan();
    for (int f = 0; f < 4; f++) begin
      dwell(2'b10, 8'h92, 20);
      dwell(2'b01, 8'hA4, 20);
      n_vec++;
      if (act !== mexp()) begin n_mis++; $display("FAIL clean_frame%0d got=%h want=%h", f, act, mexp()); end
      n_vec++;
      if (obs_upd !== (f == 0 ? 0 : 1)) begin n_mis++; $display("FAIL clean_upd%0d got=%0d want=%0d", f, obs_upd, (f == 0 ? 0 : 1)); end
    end
    n_vec++;
    if ({value_valid, value, digit_tens, digit_ones, err_count} !== {1'b1, 7'd25, 4'd2, 4'd5, 8'd0}) begin
      n_mis++; $display("FAIL clean_value got=%h want=%h", act, {1'b1, 7'd25, 4'd2, 4'd5, 8'd0});
    end
  endtask

  task automatic test_value_change();
    frame(2, 4, 20);
    frame(2, 5, 20);
    n_vec++;
    if (value !== 7'd25 || obs_upd !== exp_upd) begin
      n_mis++; $display("FAIL glitch_hold value=%0d want=25 upd=%0d want=%0d", value, obs_upd, exp_upd);
    end
    frame(2, 4, 20);
    n_vec++;
    if (act !== mexp()) begin n_mis++; $display("FAIL change_first got=%h want=%h", act, mexp()); end
    frame(2, 4, 20);
    n_vec++;
    if (value !== 7'd24 || obs_upd !== 2 || exp_upd !== 2) begin
      n_mis++; $display("FAIL change_commit value=%0d want=24 upd=%0d want=2", value, obs_upd);
    end
  endtask

  task automatic test_short_dwells();
    int a, b;
    for (int i = 0; i < 20; i++) dwell(i[0] ? 2'b01 : 2'b10, enc($urandom_range(0, 9)), 3);
    n_vec++;
    if (act !== mexp() || obs_upd !== exp_upd || obs_err !== exp_err) begin
      n_mis++; $display("FAIL short_dwell got=%h want=%h upd=%0d/%0d", act, mexp(), obs_upd, exp_upd);
    end
    a = $urandom_range(0, 9);
    b = $urandom_range(0, 9);
    if (a == 2 && b == 4) b = 7;
    frame(a, b, 20);
    frame(a, b, 20);
    n_vec++;
    if (act !== mexp() || obs_upd !== exp_upd || value !== 7'(a * 10 + b)) begin
      n_mis++; $display("FAIL short_recover got=%h want=%h upd=%0d/%0d", act, mexp(), obs_upd, exp_upd);
    end
  endtask

  task automatic test_errors();
    logic [23:0] held;
    held = act;
    dwell(2'b10, enc(3), 20);
    dwell(2'b10, 8'h2A, 20);
    n_vec++;
    if (err_count !== 8'd1 || obs_err !== 1 || act[23:8] !== held[23:8]) begin
      n_mis++; $display("FAIL err_seg count=%0d pulses=%0d got=%h want=%h", err_count, obs_err, act, {held[23:8], 8'd1});
    end
    frame(7, 1, 20);
    n_vec++;
    if (act !== mexp()) begin n_mis++; $display("FAIL err_fsm got=%h want=%h", act, mexp()); end
    dwell(2'b00, 8'h92, 20);
    n_vec++;
    if (err_count !== 8'd2 || obs_err !== exp_err) begin
      n_mis++; $display("FAIL err_sel00 count=%0d want=2 pulses=%0d/%0d", err_count, obs_err, exp_err);
    end
    for (int i = 0; i < 300; i++) dwell(2'b10, i[0] ? 8'h2B : 8'h2A, 8);
    n_vec++;
    if (err_count !== 8'd255 || act !== mexp()) begin
      n_mis++; $display("FAIL err_saturate got=%h want=%h", act, mexp());
    end
    n_vec++;
    if (obs_err !== exp_err) begin n_mis++; $display("FAIL err_pulses got=%0d want=%0d", obs_err, exp_err); end
  endtask

  task automatic test_timeout_blank();
    int a;
    a = $urandom_range(10, 99);
    frame(a / 10, a % 10, 20);
    frame(a / 10, a % 10, 20);
    n_vec++;
    if (value_valid !== 1'b1 || value !== 7'(a) || act !== mexp()) begin
      n_mis++; $display("FAIL to_precommit got=%h want=%h", act, mexp());
    end
    dwell(2'b11, 8'hFF, 250);
    n_vec++;
    if (value_valid !== 1'b0 || value !== 7'(a) || act !== mexp()) begin
      n_mis++; $display("FAIL timeout got=%h want=%h", act, mexp());
    end
    for (int f = 0; f < 2; f++) begin
      dwell(2'b10, 8'h19, 20);
      dwell(2'b01, 8'h7F, 20);
    end
    n_vec++;
    if ({value_valid, value, digit_tens, digit_ones} !== {1'b1, 7'd4, 4'd0, 4'd4} || act !== mexp()) begin
      n_mis++; $display("FAIL blank_tens got=%h want=%h", act, mexp());
    end
    n_vec++;
    if (obs_upd !== exp_upd) begin n_mis++; $display("FAIL blank_upd got=%0d want=%0d", obs_upd, exp_upd); end
  endtask

  task automatic test_reset_mid_frame();
    dwell(2'b10, enc(7), 20);
    do_reset();
    n_vec++;
    if ({act, value_update, err_pulse} !== 26'h0) begin
      n_mis++; $display("FAIL midreset got=%h want=0", {act, value_update, err_pulse});
    end
    frame(3, 7, 20);
    n_vec++;
    if (value_valid !== 1'b0 || act !== mexp()) begin
      n_mis++; $display("FAIL midreset_one got=%h want=%h", act, mexp());
    end
    frame(3, 7, 20);
    n_vec++;
    if (value !== 7'd37 || value_valid !== 1'b1 || obs_upd !== exp_upd) begin
      n_mis++; $display("FAIL midreset_two got=%h want=%h upd=%0d/%0d", act, mexp(), obs_upd, exp_upd);
    end
  endtask

  task automatic test_random_scan();
    int tt, to, k;
    bit side;
    tt = 5; to = 5; side = 0;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0)      dwell($urandom_range(0, 1) ? 2'b00 : 2'b10, 8'h2A, $urandom_range(20, 28));
      else if (k == 1) dwell(2'b10, 8'hFF, $urandom_range(20, 28));
      else if (k == 2) dwell(2'b11, 8'hFF, $urandom_range(20, 28));
      else begin
        if ($urandom_range(0, 5) == 0) begin tt = $urandom_range(0, 9); to = $urandom_range(0, 9); end
        if (side) dwell(2'b01, enc((tt == 0 && $urandom_range(0, 1)) ? 10 : tt), $urandom_range(20, 28));
        else      dwell(2'b10, enc(to), $urandom_range(20, 28));
        side = ~side;
      end
      n_vec++;
      if (act !== mexp() || obs_upd !== exp_upd || obs_err !== exp_err) begin
        n_mis++;
        $display("FAIL random_%0d got=%h want=%h upd=%0d/%0d err=%0d/%0d", i, act, mexp(), obs_upd, exp_upd, obs_err, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_scan();
    test_value_change();
    test_short_dwells();
    test_errors();
    test_timeout_blank();
    test_reset_mid_frame();
    test_random_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
